// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: opcode/funct encodings, ALU ops, mux-select codes and the
// ID/EX control bundle shared by the decode stage.
package cpu_types_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                          OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                          OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_LL = 6'h30,
                          OP_SC = 6'h38, OP_HALT = 6'h3F;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                          FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                          FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
                          FN_SLTU = 6'h2B;
   localparam logic [1:0] REGDST_RT = 2'd0, REGDST_RD = 2'd1, REGDST_RA = 2'd2;
   localparam logic [1:0] PCSRC_NEXT = 2'd0, PCSRC_REG = 2'd1, PCSRC_JUMP = 2'd2, PCSRC_BR = 2'd3;
   localparam logic [1:0] MEMTOREG_ALU = 2'd0, MEMTOREG_MEM = 2'd1, MEMTOREG_PC = 2'd2;
   localparam logic [1:0] ALUSRC_REG = 2'd0, ALUSRC_IMM = 2'd1, ALUSRC_LUI = 2'd2;

   typedef enum logic [3:0] {
      ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
   } aluop_t;

   typedef enum logic [1:0] {HS_RUN, HS_DRAIN, HS_HALTED} halt_state_t;

   typedef struct packed {
      logic [5:0] opcode;
      logic [5:0] funct;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wsel;
      logic [4:0] shamt;
      aluop_t     alu_ctr;
      logic [1:0] alu_src;
      logic [1:0] mem_to_reg;
      logic [1:0] pc_src;
      logic       reg_wr;
      logic       mem_wr;
      logic       mem_rd;
      logic       datomic;
   } ctrl_bundle_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction decode into the control bundle and
// the extended immediate.
module ctrl_decode import cpu_types_pkg::*; #(
   parameter int WORD_W = 32
) (
   input  logic [31:0]       instr_i,
   output ctrl_bundle_t      ctrl_o,
   output logic [WORD_W-1:0] imm_o
);
   logic [5:0] op, fn;
   logic       rtype, logic_imm, ialu, mem;
   logic [1:0] regdst;
   aluop_t     fn_alu;

   always_comb begin
      op = instr_i[31:26];
      fn = instr_i[5:0];
      case (fn)
         FN_SLL:          fn_alu = ALU_SLL;
         FN_SRL:          fn_alu = ALU_SRL;
         FN_SUB, FN_SUBU: fn_alu = ALU_SUB;
         FN_AND:          fn_alu = ALU_AND;
         FN_OR:           fn_alu = ALU_OR;
         FN_XOR:          fn_alu = ALU_XOR;
         FN_NOR:          fn_alu = ALU_NOR;
         FN_SLT:          fn_alu = ALU_SLT;
         FN_SLTU:         fn_alu = ALU_SLTU;
         default:         fn_alu = ALU_ADD;
      endcase
      rtype = op == OP_RTYPE;
      logic_imm = op inside {OP_ANDI, OP_ORI, OP_XORI};
      ialu = logic_imm || op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU};
      mem = op inside {OP_LW, OP_SW, OP_LL, OP_SC};
      regdst = rtype ? REGDST_RD : op == OP_JAL ? REGDST_RA : REGDST_RT;
      ctrl_o.opcode = op;
      ctrl_o.funct = fn;
      ctrl_o.rs = instr_i[25:21];
      ctrl_o.rt = instr_i[20:16];
      ctrl_o.shamt = instr_i[10:6];
      ctrl_o.wsel = regdst == REGDST_RD ? instr_i[15:11] : regdst == REGDST_RA ? 5'd31 : instr_i[20:16];
      ctrl_o.alu_ctr = rtype ? fn_alu :
                       op inside {OP_BEQ, OP_BNE} ? ALU_SUB :
                       op == OP_ANDI ? ALU_AND :
                       op == OP_ORI ? ALU_OR :
                       op == OP_XORI ? ALU_XOR :
                       op == OP_SLTI ? ALU_SLT :
                       op == OP_SLTIU ? ALU_SLTU : ALU_ADD;
      ctrl_o.alu_src = op == OP_LUI ? ALUSRC_LUI : (ialu || mem) ? ALUSRC_IMM : ALUSRC_REG;
      ctrl_o.mem_to_reg = op inside {OP_LW, OP_LL} ? MEMTOREG_MEM : op == OP_JAL ? MEMTOREG_PC : MEMTOREG_ALU;
      ctrl_o.pc_src = (rtype && fn == FN_JR) ? PCSRC_REG :
                      op inside {OP_J, OP_JAL} ? PCSRC_JUMP :
                      op inside {OP_BEQ, OP_BNE} ? PCSRC_BR : PCSRC_NEXT;
      // an all-zero word is the canonical NOP and must not write $0
      ctrl_o.reg_wr = instr_i != '0 &&
                      ((rtype && fn != FN_JR) || ialu || op inside {OP_JAL, OP_LUI, OP_LW, OP_LL, OP_SC});
      ctrl_o.mem_wr = op inside {OP_SW, OP_SC};
      ctrl_o.mem_rd = op inside {OP_LW, OP_LL};
      ctrl_o.datomic = op inside {OP_LL, OP_SC};
      imm_o = logic_imm ? WORD_W'(instr_i[15:0]) :
              op == OP_LUI ? WORD_W'({instr_i[15:0], 16'h0000}) : WORD_W'($signed(instr_i[15:0]));
   end
endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: ID/EX control register with stall/flush, HALT drain
// sequencer gating fetch, and the LL/SC link reservation.
module pipe_control_unit import cpu_types_pkg::*; #(
   parameter int WORD_W     = 32,
   parameter int HALT_DRAIN = 3,
   parameter bit LINK_EN    = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [WORD_W-1:0] if_pc,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_ll_set,
   input  logic              ex_sc_chk,
   input  logic [WORD_W-1:0] ex_addr,
   input  logic              snoop_inv,
   input  logic [WORD_W-1:0] snoop_addr,
   output logic              id_valid,
   output logic [5:0]        id_opcode,
   output logic [5:0]        id_funct,
   output logic [4:0]        id_rs,
   output logic [4:0]        id_rt,
   output logic [4:0]        id_wsel,
   output logic [4:0]        id_shamt,
   output logic [WORD_W-1:0] id_imm,
   output aluop_t            id_alu_ctr,
   output logic [1:0]        id_alu_src,
   output logic [1:0]        id_mem_to_reg,
   output logic [1:0]        id_pc_src,
   output logic              id_reg_wr,
   output logic              id_mem_wr,
   output logic              id_mem_rd,
   output logic              id_datomic,
   output logic [WORD_W-1:0] id_pc,
   output logic              iREN,
   output logic              halt,
   output logic              sc_ok
);
   localparam int CW = HALT_DRAIN > 1 ? $clog2(HALT_DRAIN) : 1;

   ctrl_bundle_t      dec, ctrl_q, ctrl_d;
   logic [WORD_W-1:0] dec_imm, imm_q, imm_d, pc_q, pc_d;
   logic              valid_q, valid_d, upd, dec_halt, rst_q;
   halt_state_t       hs_q, hs_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   ctrl_decode #(.WORD_W(WORD_W)) u_dec (.instr_i(if_instr), .ctrl_o(dec), .imm_o(dec_imm));

   always_comb begin
      upd = flush || !stall;
      valid_d = upd ? (!flush && if_valid) : valid_q;
      ctrl_d = !upd ? ctrl_q : valid_d ? dec : ctrl_bundle_t'('0);
      imm_d = !upd ? imm_q : valid_d ? dec_imm : '0;
      pc_d = !upd ? pc_q : valid_d ? if_pc : '0;
      dec_halt = if_valid && dec.opcode == OP_HALT;
      hs_d = hs_q;
      cnt_d = cnt_q;
      if (hs_q == HS_RUN && upd && valid_d && dec.opcode == OP_HALT) begin
         hs_d = HS_DRAIN;
         cnt_d = CW'(HALT_DRAIN - 1);
      end else if (hs_q == HS_DRAIN && !stall) begin
         hs_d = cnt_q == '0 ? HS_HALTED : HS_DRAIN;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= 1'b0;
         ctrl_q <= '0;
         imm_q <= '0;
         pc_q <= '0;
         hs_q <= HS_RUN;
         cnt_q <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q <= ctrl_d;
         imm_q <= imm_d;
         pc_q <= pc_d;
         hs_q <= hs_d;
         cnt_q <= cnt_d;
      end
      rst_q <= RST;
   end

   // fetch stays off for the one cycle following reset
   assign iREN = hs_q == HS_RUN && !rst_q && !dec_halt;
   assign halt = hs_q == HS_HALTED;

   assign id_valid = valid_q;
   assign id_opcode = ctrl_q.opcode;
   assign id_funct = ctrl_q.funct;
   assign id_rs = ctrl_q.rs;
   assign id_rt = ctrl_q.rt;
   assign id_wsel = ctrl_q.wsel;
   assign id_shamt = ctrl_q.shamt;
   assign id_imm = imm_q;
   assign id_alu_ctr = ctrl_q.alu_ctr;
   assign id_alu_src = ctrl_q.alu_src;
   assign id_mem_to_reg = ctrl_q.mem_to_reg;
   assign id_pc_src = ctrl_q.pc_src;
   assign id_reg_wr = ctrl_q.reg_wr;
   assign id_mem_wr = ctrl_q.mem_wr;
   assign id_mem_rd = ctrl_q.mem_rd;
   assign id_datomic = ctrl_q.datomic;
   assign id_pc = pc_q;

   generate
      if (LINK_EN) begin : g_link
         logic              link_v_q, link_v_d;
         logic [WORD_W-1:0] link_a_q, link_a_d;
         // a new LL overrides both a same-cycle SC consume and a snoop hit
         always_comb begin
            link_v_d = ex_ll_set || (link_v_q && !ex_sc_chk && !(snoop_inv && snoop_addr == link_a_q));
            link_a_d = ex_ll_set ? ex_addr : link_a_q;
         end
         always_ff @(posedge CLK) begin
            link_v_q <= RST ? 1'b0 : link_v_d;
            link_a_q <= RST ? '0 : link_a_d;
         end
         assign sc_ok = link_v_q && link_a_q == ex_addr;
      end else begin : g_nolink
         assign sc_ok = 1'b1;
      end
   endgenerate
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the decode stage.
module tb_pipe_control_unit;
   import cpu_types_pkg::*;
   localparam int D = 3;

   logic        clk = 1'b0;
   logic        RST, if_valid, stall, flush, ex_ll_set, ex_sc_chk, snoop_inv;
   logic [31:0] if_instr, if_pc, ex_addr, snoop_addr;
   logic        id_valid, id_reg_wr, id_mem_wr, id_mem_rd, id_datomic, iREN, halt, sc_ok;
   logic [5:0]  id_opcode, id_funct;
   logic [4:0]  id_rs, id_rt, id_wsel, id_shamt;
   logic [31:0] id_imm, id_pc;
   aluop_t      id_alu_ctr;
   logic [1:0]  id_alu_src, id_mem_to_reg, id_pc_src;

   always #5 clk = ~clk;

   pipe_control_unit #(.WORD_W(32), .HALT_DRAIN(D), .LINK_EN(1'b1)) dut (
      .CLK(clk), .RST(RST), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .stall(stall), .flush(flush), .ex_ll_set(ex_ll_set), .ex_sc_chk(ex_sc_chk),
      .ex_addr(ex_addr), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
      .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs),
      .id_rt(id_rt), .id_wsel(id_wsel), .id_shamt(id_shamt), .id_imm(id_imm),
      .id_alu_ctr(id_alu_ctr), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
      .id_pc_src(id_pc_src), .id_reg_wr(id_reg_wr), .id_mem_wr(id_mem_wr),
      .id_mem_rd(id_mem_rd), .id_datomic(id_datomic), .id_pc(id_pc), .iREN(iREN),
      .halt(halt), .sc_ok(sc_ok)
   );

   typedef struct {
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, ws, sh;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [1:0]  asrc, m2r, pcs;
      logic        rw, mw, mr, at;
   } exp_t;

   int          n_tests = 0, n_fail = 0;
   bit          started = 0;
   exp_t        m;
   logic        m_valid, rst_f, lv;
   logic [31:0] m_pc, la;
   int          drain_left;
   logic [5:0]  ops [19] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                             6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h30, 6'h38};
   logic [5:0]  fns [13] = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                             6'h26, 6'h27, 6'h2A, 6'h2B};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
      if (fn == 6'h00) return ALU_SLL;
      if (fn == 6'h02) return ALU_SRL;
      if (fn inside {6'h22, 6'h23}) return ALU_SUB;
      if (fn == 6'h24) return ALU_AND;
      if (fn == 6'h25) return ALU_OR;
      if (fn == 6'h26) return ALU_XOR;
      if (fn == 6'h27) return ALU_NOR;
      if (fn == 6'h2A) return ALU_SLT;
      if (fn == 6'h2B) return ALU_SLTU;
      return ALU_ADD;
   endfunction

   function automatic exp_t mdec(input logic [31:0] i);
      exp_t e;
      logic r, lg, ial, mm, br;
      e.op = i[31:26]; e.fn = i[5:0]; e.rs = i[25:21]; e.rt = i[20:16]; e.sh = i[10:6];
      r = e.op == 6'h00;
      br = e.op inside {6'h04, 6'h05};
      lg = e.op inside {6'h0C, 6'h0D, 6'h0E};
      ial = lg || e.op inside {6'h08, 6'h09, 6'h0A, 6'h0B};
      mm = e.op inside {6'h23, 6'h2B, 6'h30, 6'h38};
      e.ws = r ? i[15:11] : e.op == 6'h03 ? 5'd31 : i[20:16];
      e.imm = lg ? {16'h0, i[15:0]} : e.op == 6'h0F ? {i[15:0], 16'h0} : {{16{i[15]}}, i[15:0]};
      e.m2r = e.op inside {6'h23, 6'h30} ? 2'd1 : e.op == 6'h03 ? 2'd2 : 2'd0;
      e.pcs = (r && e.fn == 6'h08) ? 2'd1 : e.op inside {6'h02, 6'h03} ? 2'd2 : br ? 2'd3 : 2'd0;
      e.asrc = e.op == 6'h0F ? 2'd2 : (ial || mm) ? 2'd1 : 2'd0;
      e.rw = i != 0 && ((r && e.fn != 6'h08) || ial || e.op inside {6'h03, 6'h0F, 6'h23, 6'h30, 6'h38});
      e.mw = e.op inside {6'h2B, 6'h38};
      e.mr = e.op inside {6'h23, 6'h30};
      e.at = e.op inside {6'h30, 6'h38};
      e.alu = r ? rtype_alu(e.fn) : br ? ALU_SUB : e.op == 6'h0C ? ALU_AND : e.op == 6'h0D ? ALU_OR :
              e.op == 6'h0E ? ALU_XOR : e.op == 6'h0A ? ALU_SLT : e.op == 6'h0B ? ALU_SLTU : ALU_ADD;
      return e;
   endfunction

   task automatic model_step();
      logic load;
      started = 1;
      if (RST) begin
         m_valid = 0; m_pc = 0; drain_left = -1; lv = 0; la = 0; rst_f = 1;
      end else begin
         rst_f = 0;
         load = !flush && !stall && if_valid;
         if (drain_left > 0 && !stall) drain_left--;
         else if (drain_left < 0 && load && if_instr[31:26] == 6'h3F) drain_left = D;
         if (flush || !stall) begin
            m_valid = load;
            if (load) begin m = mdec(if_instr); m_pc = if_pc; end
         end
         if (ex_ll_set) begin lv = 1; la = ex_addr; end
         else if (ex_sc_chk || (snoop_inv && snoop_addr == la)) lv = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int r = $urandom_range(0, 39);
      if (r == 0) return 32'h0;
      if (r == 1) return {6'h3F, w[25:0]};
      if (r == 2) return w;
      w[31:26] = ops[$urandom_range(0, 18)];
      if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 12)];
      return w;
   endfunction

   always @(negedge clk) if (started) begin
      chk("valid", id_valid, m_valid);
      chk("reg_wr", id_reg_wr, m_valid && m.rw);
      chk("mem_wr", id_mem_wr, m_valid && m.mw);
      chk("mem_rd", id_mem_rd, m_valid && m.mr);
      chk("datomic", id_datomic, m_valid && m.at);
      if (m_valid) begin
         chk("opcode", id_opcode, m.op);
         chk("funct", id_funct, m.fn);
         chk("rs", id_rs, m.rs);
         chk("rt", id_rt, m.rt);
         chk("wsel", id_wsel, m.ws);
         chk("shamt", id_shamt, m.sh);
         chk("imm", id_imm, m.imm);
         chk("alu_ctr", id_alu_ctr, m.alu);
         chk("alu_src", id_alu_src, m.asrc);
         chk("mem_to_reg", id_mem_to_reg, m.m2r);
         chk("pc_src", id_pc_src, m.pcs);
         chk("pc", id_pc, m_pc);
      end
      chk("iREN", iREN, drain_left < 0 && !rst_f && !(if_valid && if_instr[31:26] == 6'h3F));
      chk("halt", halt, drain_left == 0);
      chk("sc_ok", sc_ok, lv && la == ex_addr);
   end

   initial begin
      {RST, if_valid, stall, flush, ex_ll_set, ex_sc_chk, snoop_inv} = 7'b1000000;
      {if_instr, if_pc, ex_addr, snoop_addr} = '0;
      tick();
      chk("rst_valid", id_valid, 0); chk("rst_imm", id_imm, 0); chk("rst_regwr", id_reg_wr, 0);
      chk("rst_iren", iREN, 0); chk("rst_halt", halt, 0); chk("rst_sc", sc_ok, 0);
      RST = 0; tick();
      chk("iren_back", iREN, 1);
      if_valid = 1; if_instr = 32'h2528FFFF; if_pc = 32'h404; tick();
      chk("addiu_imm", id_imm, 32'hFFFFFFFF); chk("addiu_wsel", id_wsel, 8);
      chk("addiu_src", id_alu_src, 1); chk("addiu_rw", id_reg_wr, 1); chk("addiu_valid", id_valid, 1);
      if_instr = 32'h35088000; tick();
      chk("ori_imm", id_imm, 32'h00008000); chk("ori_alu", id_alu_ctr, ALU_OR);
      if_instr = 32'h3C081234; tick();
      chk("lui_imm", id_imm, 32'h12340000); chk("lui_src", id_alu_src, 2);
      if_instr = 32'h0C000010; if_pc = 32'h410; tick();
      chk("jal_wsel", id_wsel, 31); chk("jal_m2r", id_mem_to_reg, 2); chk("jal_pcs", id_pc_src, 2);
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         if_instr = 32'h2528FFFF + k; if_pc = 32'h800 + k; tick();
         chk("stall_wsel", id_wsel, 31); chk("stall_pc", id_pc, 32'h410); chk("stall_imm", id_imm, 32'h10);
      end
      flush = 1; tick();
      chk("flush_valid", id_valid, 0); chk("flush_rw", id_reg_wr, 0);
      stall = 0; flush = 0; if_valid = 0;
      if_valid = 1; if_instr = 32'hFC000000; #1;
      chk("halt_iren_now", iREN, 0);
      tick();
      if_valid = 0; if_instr = 0;
      tick(); chk("drain1", halt, 0);
      stall = 1; tick(); chk("drain2", halt, 0);
      stall = 0; tick(); chk("drain3", halt, 0);
      tick(); chk("halted", halt, 1); chk("halted_iren", iREN, 0);
      RST = 1; tick(); RST = 0; tick();
      if_valid = 1; if_instr = 32'hFC000000; flush = 1; tick();
      if_valid = 0; flush = 0;
      repeat (4) tick();
      chk("flushed_halt", halt, 0); chk("flushed_iren", iREN, 1);
      ex_addr = 32'h100; ex_ll_set = 1; tick();
      ex_ll_set = 0; ex_sc_chk = 1; #1; chk("sc_hit", sc_ok, 1);
      tick(); chk("sc_second", sc_ok, 0);
      ex_sc_chk = 0; ex_ll_set = 1; tick();
      ex_ll_set = 0; snoop_inv = 1; snoop_addr = 32'h100; tick();
      snoop_inv = 0; ex_sc_chk = 1; #1; chk("sc_snooped", sc_ok, 0);
      tick(); ex_sc_chk = 0; ex_ll_set = 1; tick();
      ex_ll_set = 0; snoop_inv = 1; snoop_addr = 32'h104; tick();
      snoop_inv = 0; ex_sc_chk = 1; #1; chk("sc_other_snoop", sc_ok, 1);
      tick(); ex_sc_chk = 0; ex_ll_set = 1; snoop_inv = 1; snoop_addr = 32'h100; tick();
      ex_ll_set = 0; snoop_inv = 0; chk("ll_beats_snoop", sc_ok, 1);
      ex_ll_set = 1; ex_sc_chk = 1; #1; chk("sc_old_state", sc_ok, 1);
      tick(); ex_ll_set = 0; ex_sc_chk = 0; chk("ll_beats_sc", sc_ok, 1);
      if_valid = 1; if_instr = 32'hFC000000; tick();
      if_valid = 0; if_instr = 0; tick();
      chk("mid_drain_iren", iREN, 0);
      RST = 1; tick(); RST = 0;
      chk("rst_drain_iren", iREN, 0); chk("rst_drain_halt", halt, 0);
      tick(); chk("rst_drain_run", iREN, 1);
      ex_addr = 32'h100; #1; chk("rst_link_100", sc_ok, 0);
      ex_addr = 32'h200; #1; chk("rst_link_200", sc_ok, 0);
      for (int c = 0; c < 4000; c++) begin
         RST = $urandom_range(0, 59) == 0;
         stall = $urandom_range(0, 6) == 0;
         flush = $urandom_range(0, 9) == 0;
         if_valid = $urandom_range(0, 3) != 0;
         if_instr = rand_instr();
         if_pc = $urandom;
         ex_ll_set = $urandom_range(0, 4) == 0;
         ex_sc_chk = $urandom_range(0, 4) == 0;
         snoop_inv = $urandom_range(0, 4) == 0;
         ex_addr = 32'h100 + 32'($urandom_range(0, 2)) * 4;
         snoop_addr = 32'h100 + 32'($urandom_range(0, 2)) * 4;
         tick();
      end
      {RST, if_valid, stall, flush, ex_ll_set, ex_sc_chk, snoop_inv} = '0;
      tick(); tick();
      @(negedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
